// File: rtl/perceptron_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : perceptron_sequencer
//  Description : Sequences one perceptron evaluation in signed fixed point.
//                Streams N_INPUTS input/weight pairs from sync-read memories,
//                multiply-accumulates them with saturation on top of a bias,
//                applies a step activation and offers the result on a
//                valid/ready output.
//  Revision    : 1.0 - initial release
// ============================================================================
module perceptron_sequencer #(
    parameter int SIGN     = 1,
    parameter int Q_M      = 15,
    parameter int Q_N      = 16,
    parameter int N_INPUTS = 4,
    parameter int W        = SIGN + Q_M + Q_N,
    parameter int ADDR_W   = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [W-1:0]      bias,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [W-1:0]      x_data,
    input  logic [W-1:0]      w_data,
    output logic              busy,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [W-1:0]      summation,
    output logic [W-1:0]      activation
);

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_FETCH = 3'd1;
    localparam logic [2:0] c_DRAIN = 3'd2;
    localparam logic [2:0] c_ACT   = 3'd3;
    localparam logic [2:0] c_DONE  = 3'd4;

    localparam logic [W-1:0]      c_MAX      = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0]      c_MIN      = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0]      c_ONE      = {{(W-1){1'b0}}, 1'b1} << Q_N;
    localparam logic [ADDR_W-1:0] c_LAST     = ADDR_W'(N_INPUTS - 1);
    localparam logic [ADDR_W-1:0] c_ADDR_ONE = ADDR_W'(1);

    logic [2:0]        r_state;
    logic [W-1:0]      r_acc;
    logic              r_mac_en;
    logic              r_rd_en;
    logic [ADDR_W-1:0] r_rd_addr;
    logic              r_out_valid;
    logic [W-1:0]      r_summation;
    logic [W-1:0]      r_activation;

    logic [2*W-1:0]    w_xe;
    logic [2*W-1:0]    w_we;
    logic [2*W-1:0]    w_prod;
    logic [2*W-1:0]    w_shift;
    logic              w_prod_fits;
    logic [W-1:0]      w_prod_sat;
    logic [W:0]        w_sum;
    logic [W-1:0]      w_sum_sat;
    logic [W-1:0]      w_step;

    // Saturating MAC datapath: full-width product, floor shift, clamp, clamped add
    always_comb begin
        w_xe        = {{W{x_data[W-1]}}, x_data};
        w_we        = {{W{w_data[W-1]}}, w_data};
        w_prod      = w_xe * w_we;
        w_shift     = $signed(w_prod) >>> Q_N;
        w_prod_fits = (w_shift[2*W-1:W-1] == '0) || (w_shift[2*W-1:W-1] == '1);
        if (w_prod_fits) begin
            w_prod_sat = w_shift[W-1:0];
        end else if (w_shift[2*W-1]) begin
            w_prod_sat = c_MIN;
        end else begin
            w_prod_sat = c_MAX;
        end
        w_sum = {r_acc[W-1], r_acc} + {w_prod_sat[W-1], w_prod_sat};
        if (w_sum[W] == w_sum[W-1]) begin
            w_sum_sat = w_sum[W-1:0];
        end else if (w_sum[W]) begin
            w_sum_sat = c_MIN;
        end else begin
            w_sum_sat = c_MAX;
        end
        // Strictly positive sums fire; zero and negative sums do not
        if (!r_acc[W-1] && (r_acc != '0)) begin
            w_step = c_ONE;
        end else begin
            w_step = '0;
        end
    end

    // Sequencer FSM, read strobe generation, accumulator and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= c_IDLE;
            r_acc        <= '0;
            r_mac_en     <= 1'b0;
            r_rd_en      <= 1'b0;
            r_rd_addr    <= '0;
            r_out_valid  <= 1'b0;
            r_summation  <= '0;
            r_activation <= '0;
        end else begin
            // Memory data returns one cycle after the strobe, so the MAC
            // enable is simply the strobe delayed by one cycle.
            r_mac_en <= r_rd_en;
            if (r_mac_en) begin
                r_acc <= w_sum_sat;
            end
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_acc     <= bias;
                        r_rd_en   <= 1'b1;
                        r_rd_addr <= '0;
                        r_state   <= c_FETCH;
                    end
                end
                c_FETCH: begin
                    if (r_rd_addr == c_LAST) begin
                        r_rd_en <= 1'b0;
                        r_state <= c_DRAIN;
                    end else begin
                        r_rd_addr <= r_rd_addr + c_ADDR_ONE;
                    end
                end
                c_DRAIN: begin
                    r_state <= c_ACT;
                end
                c_ACT: begin
                    r_summation  <= r_acc;
                    r_activation <= w_step;
                    r_out_valid  <= 1'b1;
                    r_state      <= c_DONE;
                end
                c_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= c_IDLE;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign rd_en      = r_rd_en;
    assign rd_addr    = r_rd_addr;
    assign busy       = (r_state != c_IDLE);
    assign out_valid  = r_out_valid;
    assign summation  = r_summation;
    assign activation = r_activation;

endmodule
`default_nettype wire
